pulse_integrator_bram: RTL and testbench

- Coherent pulse integrator for the SAR receive chain. It sums n_pulses consecutive pulses of n_samples each, sample by sample, per lane.
- The running sums live in an internal dual-port BRAM, so no external FIFO loop is needed.
- It emits one integrated pulse per frame, gated to a configurable range window, on an AXI-Stream master with full backpressure.
- It sits between the ADC/decimator stream and the DMA writer.

---
 rtl/pulse_integrator_bram.sv | 213 +++++++++++++++++++++
 tb/tb_pulse_integrator_bram.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_integrator_bram.sv
// Coherent pulse integrator: sums n_pulses pulses sample-wise per lane in an
// internal BRAM and streams the range-gated result on an AXI-Stream master.
module pulse_integrator_bram #(
    parameter int LANES      = 2,
    parameter int LANE_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int ADDR_WIDTH = 12,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [LANES*LANE_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [LANES*ACC_WIDTH-1:0]  m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    input  logic                        cfg_enable,
    input  logic [7:0]                  n_pulses,
    input  logic [ADDR_WIDTH:0]         n_samples,
    input  logic [ADDR_WIDTH-1:0]       start_index,
    input  logic [ADDR_WIDTH-1:0]       end_index,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        overflow
);

    localparam int DW    = LANES * ACC_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   NS_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   NS_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] A_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ACC_WIDTH-1:0]  ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0]  ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nxt;

    logic [7:0]            np_q, np_c;
    logic [ADDR_WIDTH:0]   ns_q, ns_c, ns_m1;
    logic [ADDR_WIDTH-1:0] st_q, en_q, last_idx;
    logic [ADDR_WIDTH-1:0] s_q;
    logic [7:0]            p_q;

    logic pipe_en, accept, s_wrap, p_last, frame_end, load;
    logic in_win;

    logic                        s1_valid;
    logic [LANES*LANE_WIDTH-1:0] s1_data;
    logic [ADDR_WIDTH-1:0]       s1_addr;
    logic                        s1_first, s1_last, s1_win;
    logic                        s1_tlast, s1_end;

    logic [DW-1:0]    mem [0:DEPTH-1];
    logic [DW-1:0]    rd_data;
    logic [DW-1:0]    sum_w;
    logic [LANES-1:0] lane_ovf;
    logic             wr_en;

    assign np_c = (n_pulses == 8'd0) ? 8'd1 : n_pulses;

    always_comb begin
        if (n_samples == '0)
            ns_c = NS_ONE;
        else if (n_samples > NS_MAX)
            ns_c = NS_MAX;
        else
            ns_c = n_samples;
    end

    assign pipe_en   = !(m_axis_tvalid && !m_axis_tready);
    assign accept    = s_axis_tvalid && s_axis_tready;
    assign ns_m1     = ns_q - NS_ONE;
    assign s_wrap    = ({1'b0, s_q} == ns_m1);
    assign p_last    = (p_q == np_q - 8'd1);
    assign frame_end = accept && s_wrap && p_last;
    assign load      = cfg_enable && ((state == IDLE) || frame_end);
    assign in_win    = (s_q >= st_q) && (s_q <= en_q);
    assign last_idx  = (en_q < ns_m1[ADDR_WIDTH-1:0]) ? en_q
                                                      : ns_m1[ADDR_WIDTH-1:0];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_enable) state_nxt = RUN;
            RUN:     if (frame_end && !cfg_enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = 1'b0;
        busy          = 1'b0;
        case (state)
            RUN: begin
                s_axis_tready = pipe_en;
                busy          = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            np_q <= 8'd1;
            ns_q <= NS_ONE;
            st_q <= '0;
            en_q <= '0;
            s_q  <= '0;
            p_q  <= '0;
        end else begin
            if (load) begin
                np_q <= np_c;
                ns_q <= ns_c;
                st_q <= start_index;
                en_q <= end_index;
            end
            if (state == IDLE) begin
                s_q <= '0;
                p_q <= '0;
            end else if (accept) begin
                if (s_wrap) begin
                    s_q <= '0;
                    p_q <= p_last ? 8'd0 : p_q + 8'd1;
                end else begin
                    s_q <= s_q + A_ONE;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_addr  <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_win   <= 1'b0;
            s1_tlast <= 1'b0;
            s1_end   <= 1'b0;
        end else if (pipe_en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_data  <= s_axis_tdata;
                s1_addr  <= s_q;
                s1_first <= (p_q == 8'd0);
                s1_last  <= p_last;
                s1_win   <= in_win;
                s1_tlast <= (s_q == last_idx);
                s1_end   <= s_wrap && p_last;
            end
        end
    end

    assign wr_en = pipe_en && s1_valid && !s1_last;

    // Write-first: a read colliding with the stage-2 write sees the new sum
    always_ff @(posedge aclk) begin
        if (wr_en)
            mem[s1_addr] <= sum_w;
        if (accept)
            rd_data <= (wr_en && s1_addr == s_q) ? sum_w : mem[s_q];
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [ACC_WIDTH:0] prev, inc, full;
        logic                      ovf;

        assign prev = s1_first ? '0
                    : {rd_data[i*ACC_WIDTH + ACC_WIDTH - 1],
                       rd_data[i*ACC_WIDTH +: ACC_WIDTH]};
        assign inc  = (ACC_WIDTH+1)'($signed(s1_data[i*LANE_WIDTH +: LANE_WIDTH]));
        assign full = prev + inc;
        assign ovf  = full[ACC_WIDTH] ^ full[ACC_WIDTH-1];
        assign lane_ovf[i] = ovf;
        assign sum_w[i*ACC_WIDTH +: ACC_WIDTH] =
            (SATURATE && ovf) ? (full[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                              : full[ACC_WIDTH-1:0];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            frame_done <= pipe_en && s1_valid && s1_end;
            if (pipe_en && s1_valid && |lane_ovf)
                overflow <= 1'b1;
            if (pipe_en && s1_valid && s1_last && s1_win) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= sum_w;
                m_axis_tlast  <= s1_tlast;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_integrator_bram.sv
// Bench for pulse_integrator_bram: three instances (24b sat, 17b sat, 17b wrap)
// share one stimulus stream and are scored against a frame-level sum model.
module tb_pulse_integrator_bram;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        m_tready;
    logic        cfg_enable;
    logic [7:0]  n_pulses;
    logic [12:0] n_samples;
    logic [11:0] start_index, end_index;

    logic        sr_a, sr_b, sr_c;
    logic [47:0] td_a;
    logic [33:0] td_b, td_c;
    logic        tv_a, tv_b, tv_c;
    logic        tl_a, tl_b, tl_c;
    logic        busy_a, busy_b, busy_c;
    logic        fd_a, fd_b, fd_c;
    logic        ovf_a, ovf_b, ovf_c;

    int n_cmp = 0;
    int n_err = 0;
    int fd_cnt = 0;
    bit bp = 1'b0;

    int cfg_np, cfg_ns, cfg_st, cfg_en;
    int s0[$], s1[$];
    logic [47:0] qa[$], ea[$];
    logic [33:0] qb[$], eb[$], qc[$], ec[$];
    bit          ql[$], el[$];
    bit          ovf_e[3];

    pulse_integrator_bram u_a (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(sr_a),
        .m_axis_tdata(td_a), .m_axis_tvalid(tv_a), .m_axis_tready(m_tready),
        .m_axis_tlast(tl_a), .cfg_enable(cfg_enable), .n_pulses(n_pulses),
        .n_samples(n_samples), .start_index(start_index), .end_index(end_index),
        .busy(busy_a), .frame_done(fd_a), .overflow(ovf_a)
    );

    pulse_integrator_bram #(.ACC_WIDTH(17), .SATURATE(1'b1)) u_b (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(sr_b),
        .m_axis_tdata(td_b), .m_axis_tvalid(tv_b), .m_axis_tready(m_tready),
        .m_axis_tlast(tl_b), .cfg_enable(cfg_enable), .n_pulses(n_pulses),
        .n_samples(n_samples), .start_index(start_index), .end_index(end_index),
        .busy(busy_b), .frame_done(fd_b), .overflow(ovf_b)
    );

    pulse_integrator_bram #(.ACC_WIDTH(17), .SATURATE(1'b0)) u_c (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(sr_c),
        .m_axis_tdata(td_c), .m_axis_tvalid(tv_c), .m_axis_tready(m_tready),
        .m_axis_tlast(tl_c), .cfg_enable(cfg_enable), .n_pulses(n_pulses),
        .n_samples(n_samples), .start_index(start_index), .end_index(end_index),
        .busy(busy_c), .frame_done(fd_c), .overflow(ovf_c)
    );

    initial forever #5 aclk = ~aclk;

    initial forever begin
        @(posedge aclk);
        #1;
        m_tready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    always @(negedge aclk) begin
        if (aresetn) begin
            if (tv_a && m_tready) begin
                qa.push_back(td_a);
                ql.push_back(tl_a);
            end
            if (tv_b && m_tready) qb.push_back(td_b);
            if (tv_c && m_tready) qc.push_back(td_c);
            if (fd_a) fd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_np();
        return (cfg_np == 0) ? 1 : cfg_np;
    endfunction

    function automatic int eff_ns();
        return (cfg_ns == 0) ? 1 : ((cfg_ns > 4096) ? 4096 : cfg_ns);
    endfunction

    // Reduce an exact sum to a w-bit signed result, noting any overflow
    function automatic longint fold(input longint v, input int w,
                                    input bit sat, input int d);
        longint lo = -(longint'(1) <<< (w - 1));
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint m;
        if (v >= lo && v <= hi) return v;
        ovf_e[d] = 1'b1;
        if (sat) return (v > hi) ? hi : lo;
        m = v & ((longint'(1) <<< w) - 1);
        return (m > hi) ? m - (longint'(1) <<< w) : m;
    endfunction

    task automatic model_frame();
        int np = eff_np();
        int ns = eff_ns();
        int hi = (cfg_en < ns - 1) ? cfg_en : ns - 1;
        longint a[3][2];
        for (int k = 0; k < ns; k++) begin
            for (int d = 0; d < 3; d++) begin
                for (int l = 0; l < 2; l++) begin
                    a[d][l] = 0;
                    for (int p = 0; p < np; p++)
                        a[d][l] = fold(a[d][l] + longint'(l == 0 ? s0[p*ns+k] : s1[p*ns+k]),
                                       (d == 0) ? 24 : 17, d != 2, d);
                end
            end
            if (k >= cfg_st && k <= cfg_en) begin
                ea.push_back({24'(a[0][1]), 24'(a[0][0])});
                eb.push_back({17'(a[1][1]), 17'(a[1][0])});
                ec.push_back({17'(a[2][1]), 17'(a[2][0])});
                el.push_back(k == hi);
            end
        end
    endtask

    task automatic set_cfg(input int np, input int ns, input int st, input int en);
        cfg_np = np; cfg_ns = ns; cfg_st = st; cfg_en = en;
        n_pulses = 8'(np);
        n_samples = 13'(ns);
        start_index = 12'(st);
        end_index = 12'(en);
    endtask

    task automatic gen_ramp();
        s0.delete(); s1.delete();
        for (int p = 0; p < eff_np(); p++)
            for (int k = 0; k < eff_ns(); k++) begin
                s0.push_back(k);
                s1.push_back(-k);
            end
    endtask

    task automatic gen_const(input int v0, input int v1);
        s0.delete(); s1.delete();
        for (int i = 0; i < eff_np() * eff_ns(); i++) begin
            s0.push_back(v0);
            s1.push_back(v1);
        end
    endtask

    task automatic run_frame(input bit keep_en, input int limit);
        bit ok;
        cfg_enable = 1'b1;
        for (int i = 0; i < s0.size() && i < limit; i++) begin
            s_tdata = {16'(s1[i]), 16'(s0[i])};
            s_tvalid = 1'b1;
            ok = 1'b0;
            for (int w = 0; w < 500 && !ok; w++) begin
                @(negedge aclk);
                if (i > 0) chk("tready_vs_pending", sr_a, !(tv_a && !m_tready));
                ok = sr_a;
                @(posedge aclk);
                #1;
            end
            chk("s_accept", ok, 1);
            if (!ok) break;
            if (!keep_en) cfg_enable = 1'b0;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        bit done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge aclk);
            done = (fd_cnt >= target) && !tv_a && !tv_b && !tv_c;
        end
        repeat (4) @(negedge aclk);
        chk("frame_done_count", fd_cnt, target);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_count_a"}, qa.size(), ea.size());
        chk({tag, "_count_b"}, qb.size(), eb.size());
        chk({tag, "_count_c"}, qc.size(), ec.size());
        for (int i = 0; i < ea.size() && i < qa.size(); i++) begin
            chk({tag, "_data_a"}, qa[i], ea[i]);
            chk({tag, "_tlast"}, ql[i], el[i]);
        end
        for (int i = 0; i < eb.size() && i < qb.size(); i++)
            chk({tag, "_data_b"}, qb[i], eb[i]);
        for (int i = 0; i < ec.size() && i < qc.size(); i++)
            chk({tag, "_data_c"}, qc[i], ec[i]);
        chk({tag, "_ovf_a"}, ovf_a, ovf_e[0]);
        chk({tag, "_ovf_b"}, ovf_b, ovf_e[1]);
        chk({tag, "_ovf_c"}, ovf_c, ovf_e[2]);
        qa.delete(); qb.delete(); qc.delete(); ql.delete();
        ea.delete(); eb.delete(); ec.delete(); el.delete();
        fd_cnt = 0;
    endtask

    initial begin
        logic signed [15:0] r;
        aresetn = 1'b0;
        s_tdata = '0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        cfg_enable = 1'b0;
        set_cfg(1, 1, 0, 0);
        ovf_e = '{0, 0, 0};
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_s_tready", sr_a, 0);
        chk("rst_tvalid", tv_a, 0);
        chk("rst_tlast", tl_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_frame_done", fd_a, 0);
        chk("rst_overflow", ovf_a, 0);
        chk("rst_tdata", td_a, 0);
        chk("rst_tvalid_b", tv_b, 0);
        @(posedge aclk);
        #1 aresetn = 1'b1;

        set_cfg(4, 8, 0, 7);
        gen_ramp();
        model_frame();
        run_frame(0, 1 << 20);
        wait_done(1);
        check_outputs("ramp");
        chk("idle_busy", busy_a, 0);

        bp = 1'b1;
        model_frame();
        run_frame(0, 1 << 20);
        wait_done(1);
        check_outputs("ramp_bp");
        bp = 1'b0;

        set_cfg(3, 8, 2, 5);
        gen_const(1, 0);
        model_frame();
        model_frame();
        run_frame(1, 1 << 20);
        run_frame(0, 1 << 20);
        wait_done(2);
        check_outputs("window");

        set_cfg(5, 1, 0, 0);
        s0 = '{10, 20, 30, 40, 50};
        s1 = '{0, 0, 0, 0, 0};
        model_frame();
        run_frame(0, 1 << 20);
        wait_done(1);
        check_outputs("fwd_ns1");

        set_cfg(4, 2, 0, 1);
        gen_const(32767, -32768);
        model_frame();
        run_frame(0, 1 << 20);
        wait_done(1);
        check_outputs("sat");

        set_cfg(5, 1, 0, 0);
        s0 = '{1, 2, 3, 4, 5};
        s1 = '{-1, -2, -3, -4, -5};
        model_frame();
        run_frame(0, 1 << 20);
        wait_done(1);
        check_outputs("ovf_sticky");

        set_cfg(4, 8, 0, 7);
        gen_ramp();
        run_frame(0, 19);
        repeat (2) @(posedge aclk);
        #3 aresetn = 1'b0;
        ovf_e = '{0, 0, 0};
        repeat (3) @(negedge aclk);
        chk("abort_tvalid", tv_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_overflow", ovf_b, 0);
        chk("abort_no_output", qa.size(), 0);
        cfg_enable = 1'b1;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        model_frame();
        run_frame(0, 1 << 20);
        wait_done(1);
        check_outputs("after_reset");

        bp = 1'b1;
        for (int t = 0; t < 6; t++) begin
            set_cfg($urandom_range(0, 4), $urandom_range(0, 12),
                    $urandom_range(0, 12), $urandom_range(0, 12));
            s0.delete(); s1.delete();
            for (int i = 0; i < eff_np() * eff_ns(); i++) begin
                r = 16'($urandom);
                s0.push_back(int'(r));
                r = 16'($urandom);
                s1.push_back(int'(r));
            end
            model_frame();
            run_frame(0, 1 << 20);
            wait_done(1);
            check_outputs("random");
        end
        bp = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
